// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bundle for serial_subtractor.
// The ovf signal exists only when OVF_DETECT_EN is defined.
interface serial_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] y;
    logic             bout;
`ifdef OVF_DETECT_EN
    logic             ovf;

    modport master (
        output start, a, b, bin,
        input  busy, done, y, bout, ovf
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, y, bout, ovf
    );
`else
    modport master (
        output start, a, b, bin,
        input  busy, done, y, bout
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, y, bout
    );
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: y = a - b - bin (mod 2**WIDTH) with borrow-out.
// One full-adder slice is reused over WIDTH cycles computing a + ~b + ~bin,
// LSB first. Optional signed-overflow output is built when OVF_DETECT_EN
// is defined.
//
// state | meaning
// IDLE  | waiting for start; operands are latched on an accepted start
// RUN   | one bit per cycle, LSB first; last bit moves to DONE
// DONE  | result registers just loaded; done pulse follows on the next cycle
//
// The done pulse is registered from the DONE state, so it appears WIDTH+1
// edges after the start edge, while y/bout/ovf are already stable.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    serial_subtractor_if.slave  bus
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [WIDTH-2:0] shreg;
    logic [WIDTH-1:0] y_q;
    logic             bout_q;
    logic             done_q;

    logic             a_bit;
    logic             nb_bit;
    logic             sum;
    logic             carry_next;
    logic [WIDTH-1:0] sh_full;
    logic             last_bit;
    logic             accept;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Full-adder slice on the current bit; sh_full is the result with this bit on top
    always_comb begin
        a_bit      = a_q[cnt];
        nb_bit     = ~b_q[cnt];
        sum        = a_bit ^ nb_bit ^ carry;
        carry_next = (a_bit & nb_bit) | (a_bit & carry) | (nb_bit & carry);
        sh_full    = {sum, shreg};
        last_bit   = (cnt == LAST_BIT);
        accept     = (state == IDLE) && bus.start;
    end

    // Operand latch, bit counter, carry and partial-result shift register
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q   <= '0;
            b_q   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            shreg <= '0;
        end else if (accept) begin
            a_q   <= bus.a;
            b_q   <= bus.b;
            carry <= ~bus.bin;
            cnt   <= '0;
            shreg <= '0;
        end else if (state == RUN) begin
            carry <= carry_next;
            cnt   <= cnt + CW'(1);
            shreg <= sh_full[WIDTH-1:1];
        end
    end

    // Result registers load only as the last bit completes; done follows DONE by one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            y_q    <= '0;
            bout_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state == DONE);
            if ((state == RUN) && last_bit) begin
                y_q    <= sh_full;
                bout_q <= ~carry_next;
            end
        end
    end

`ifdef OVF_DETECT_EN
    logic ovf_q;

    // Two's-complement overflow: operand signs differ and result sign differs from a
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if ((state == RUN) && last_bit) begin
            ovf_q <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sum != a_q[WIDTH-1]);
        end
    end

    assign bus.ovf = ovf_q;
`endif

    assign bus.busy = (state == RUN) || (state == DONE);
    assign bus.done = done_q;
    assign bus.y    = y_q;
    assign bus.bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=4). Expected results are
// computed from the arithmetic definition when an operation is issued and
// compared when done pulses. Define OVF_DETECT_EN to also cover ovf.
module tb_serial_subtractor;

    localparam int W = 4;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    int   done_cnt;
    logic [5:0] exp_q[$];

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] model(input logic [3:0] a, input logic [3:0] b, input logic bin);
        logic [3:0] d;
        logic       bo;
        logic       ov;
        d  = a - b - {3'b000, bin};
        bo = ({1'b0, a} < ({1'b0, b} + {4'b0000, bin}));
`ifdef OVF_DETECT_EN
        ov = (a[3] != b[3]) && (d[3] != a[3]);
`else
        ov = 1'b0;
`endif
        return {d, bo, ov};
    endfunction

    function automatic logic got_ovf();
`ifdef OVF_DETECT_EN
        return bus.ovf;
`else
        return 1'b0;
`endif
    endfunction

    // Scoreboard: every done pulse pops and compares one expected result
    always @(posedge clk) begin
        #1;
        if (bus.done === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                logic [5:0] e;
                e = exp_q.pop_front();
                check("result_y_bout_ovf", {26'd0, bus.y, bus.bout, got_ovf()}, {26'd0, e});
            end
        end
    end

    // Drive one start; returns 1ns after the start edge with inputs scrambled
    task automatic start_op(input logic [3:0] a, input logic [3:0] b, input logic bin,
                            input bit expect_result);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.bin   = bin;
        if (expect_result) exp_q.push_back(model(a, b, bin));
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = 4'($urandom);
        bus.b     = 4'($urandom);
        bus.bin   = 1'($urandom);
    endtask

    task automatic wait_done(output int n);
        bit seen;
        seen = 0;
        n    = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.done === 1'b1) begin
                seen = 1;
                break;
            end
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic bin,
                          input bit check_lat);
        int n;
        start_op(a, b, bin, 1);
        check("busy_after_start", {31'd0, bus.busy}, 32'd1);
        wait_done(n);
        if (check_lat) check("done_latency", n, 32'd5);
    endtask

    initial begin
        int n;
        int cnt0;
        n_checks  = 0;
        n_errors  = 0;
        done_cnt  = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.bin   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_done", {31'd0, bus.done}, 32'd0);
        check("reset_y", {28'd0, bus.y}, 32'd0);
        check("reset_bout", {31'd0, bus.bout}, 32'd0);
        check("reset_ovf", {31'd0, got_ovf()}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // 5-3 with latency and single-cycle done
        run_op(4'd5, 4'd3, 1'b0, 1);
        check("y_5_3", {28'd0, bus.y}, 32'h2);
        @(posedge clk);
        #1;
        check("done_one_cycle", {31'd0, bus.done}, 32'd0);
        check("y_held", {28'd0, bus.y}, 32'h2);

        run_op(4'd3, 4'd5, 1'b0, 1);
        check("bout_3_5", {31'd0, bus.bout}, 32'd1);
        run_op(4'd0, 4'd0, 1'b1, 1);
        check("y_0_0_bin", {28'd0, bus.y}, 32'hF);

        // back-to-back: second start in the cycle after done
        run_op(4'd15, 4'd15, 1'b0, 1);
        @(posedge clk);
        run_op(4'd8, 4'd1, 1'b0, 1);
        check("y_8_1", {28'd0, bus.y}, 32'h7);

        // start while busy is ignored
        cnt0 = done_cnt;
        start_op(4'd6, 4'd1, 1'b0, 1);
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 4'd9;
        bus.b     = 4'd2;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(n);
        check("y_6_1_ignored", {28'd0, bus.y}, 32'h5);
        repeat (8) @(posedge clk);
        #1;
        check("single_done", done_cnt - cnt0, 32'd1);

        // reset during the second RUN cycle discards the operation
        cnt0 = done_cnt;
        start_op(4'd7, 4'd2, 1'b0, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrun_busy", {31'd0, bus.busy}, 32'd0);
        check("midrun_done", {31'd0, bus.done}, 32'd0);
        check("midrun_y", {28'd0, bus.y}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("no_done_after_reset", done_cnt - cnt0, 32'd0);

        // wrap-around and random operations
        run_op(4'd0, 4'd1, 1'b0, 1);
        check("wrap_y", {28'd0, bus.y}, 32'hF);
`ifdef OVF_DETECT_EN
        run_op(4'b0111, 4'b1000, 1'b0, 1);
        check("ovf_set", {31'd0, bus.ovf}, 32'd1);
        run_op(4'b0011, 4'b0001, 1'b0, 1);
        check("ovf_clear", {31'd0, bus.ovf}, 32'd0);
`endif
        for (int i = 0; i < 12; i++) begin
            run_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   1'($urandom_range(0, 1)), 1);
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
